// File: rtl/imem_ahb_arbiter.sv
// Shares the single-port instruction RAM between the fetch port and the debug AHB-Lite slave.
// Debug normally wins the RAM slot; a starvation counter forces a fetch grant after STARVE_LIMIT denials.
module imem_ahb_arbiter #(
  parameter int IMEM_AW      = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic [IMEM_AW+1:0] cpu_addr,
  output logic               cpu_gnt,
  output logic               cpu_rvalid,
  output logic [31:0]        cpu_rdata,
  input  logic               imem_dbg_ahb_HSEL,
  input  logic [15:0]        imem_dbg_ahb_HADDR,
  input  logic [1:0]         imem_dbg_ahb_HTRANS,
  input  logic               imem_dbg_ahb_HWRITE,
  input  logic [2:0]         imem_dbg_ahb_HSIZE,
  input  logic               imem_dbg_ahb_HREADY,
  input  logic [31:0]        imem_dbg_ahb_HWDATA,
  output logic [31:0]        imem_dbg_ahb_HRDATA,
  output logic               imem_dbg_ahb_HREADYOUT,
  output logic               imem_dbg_ahb_HRESP,
  output logic               ram_en,
  output logic [3:0]         ram_we,
  output logic [IMEM_AW-1:0] ram_addr,
  output logic [31:0]        ram_wdata,
  input  logic [31:0]        ram_rdata
);

  localparam int             CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]  LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [2:0] {IDLE, D_PEND, D_RDATA, ERR1, ERR2} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [IMEM_AW+1:0] r_haddr;
  logic               r_hwrite;
  logic [2:0]         r_hsize;
  logic [CW-1:0]      r_starve_cnt;
  logic [31:0]        r_hrdata;
  logic               r_cpu_rvalid;

  logic               w_capture;
  logic               w_err;
  logic               w_dbg_win;
  logic               w_dbg_ram;
  logic               w_hreadyout;
  logic               w_hresp;
  logic               w_cpu_gnt;
  logic [3:0]         w_be;
  logic               w_unused;

  assign w_unused = ^{cpu_addr[1:0], imem_dbg_ahb_HTRANS[0]};

  // Decode of the transfer presented in the address phase.
  always_comb begin
    w_err = 1'b0;
    if (imem_dbg_ahb_HSIZE > 3'd2)
      w_err = 1'b1;
    else if (imem_dbg_ahb_HSIZE == 3'd1 && imem_dbg_ahb_HADDR[0])
      w_err = 1'b1;
    else if (imem_dbg_ahb_HSIZE == 3'd2 && imem_dbg_ahb_HADDR[1:0] != 2'b00)
      w_err = 1'b1;
    if ((imem_dbg_ahb_HADDR >> (IMEM_AW + 2)) != 16'd0)
      w_err = 1'b1;
  end

  always_comb begin
    case (r_hsize)
      3'd0:    w_be = 4'b0001 << r_haddr[1:0];
      3'd1:    w_be = 4'b0011 << {r_haddr[1], 1'b0};
      default: w_be = 4'b1111;
    endcase
  end

  // The fetch port only loses when debug holds the slot and is not yet starving the CPU.
  assign w_dbg_win = !(cpu_req && r_starve_cnt == LIMIT);

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    w_next      = r_state;
    w_hreadyout = 1'b1;
    w_hresp     = 1'b0;
    w_dbg_ram   = 1'b0;
    case (r_state)
      IDLE: ;
      D_PEND: begin
        if (w_dbg_win) begin
          w_dbg_ram = 1'b1;
          if (!r_hwrite) begin
            w_hreadyout = 1'b0;
            w_next      = D_RDATA;
          end
        end else begin
          w_hreadyout = 1'b0;
        end
      end
      D_RDATA: ;
      ERR1: begin
        w_hresp     = 1'b1;
        w_hreadyout = 1'b0;
        w_next      = ERR2;
      end
      ERR2: w_hresp = 1'b1;
      default: w_next = IDLE;
    endcase
    // Any cycle that completes a data phase may also accept the next address phase.
    w_capture = imem_dbg_ahb_HSEL & imem_dbg_ahb_HREADY & imem_dbg_ahb_HTRANS[1] & w_hreadyout;
    if (w_capture)
      w_next = w_err ? ERR1 : D_PEND;
    else if (w_hreadyout)
      w_next = IDLE;
  end

  assign w_cpu_gnt = cpu_req & ~reset & ~(r_state == D_PEND && w_dbg_win);

  assign cpu_gnt    = w_cpu_gnt;
  assign cpu_rvalid = r_cpu_rvalid;
  assign cpu_rdata  = ram_rdata;

  assign ram_en    = w_cpu_gnt | w_dbg_ram;
  assign ram_we    = (w_dbg_ram && r_hwrite) ? w_be : 4'b0000;
  assign ram_addr  = w_cpu_gnt ? cpu_addr[IMEM_AW+1:2] : r_haddr[IMEM_AW+1:2];
  assign ram_wdata = imem_dbg_ahb_HWDATA;

  assign imem_dbg_ahb_HREADYOUT = w_hreadyout;
  assign imem_dbg_ahb_HRESP     = w_hresp;
  assign imem_dbg_ahb_HRDATA    = (r_state == D_RDATA) ? ram_rdata : r_hrdata;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_haddr      <= '0;
      r_hwrite     <= 1'b0;
      r_hsize      <= 3'd0;
      r_starve_cnt <= '0;
      r_hrdata     <= 32'd0;
      r_cpu_rvalid <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cpu_rvalid <= w_cpu_gnt;
      if (w_capture) begin
        r_haddr  <= imem_dbg_ahb_HADDR[IMEM_AW+1:0];
        r_hwrite <= imem_dbg_ahb_HWRITE;
        r_hsize  <= imem_dbg_ahb_HSIZE;
      end
      if (cpu_req && !w_cpu_gnt)
        r_starve_cnt <= (r_starve_cnt == LIMIT) ? r_starve_cnt : r_starve_cnt + 1'b1;
      else
        r_starve_cnt <= '0;
      if (r_state == D_RDATA)
        r_hrdata <= ram_rdata;
    end
  end

endmodule

// File: doc/imem_ahb_arbiter.md
Name: imem_ahb_arbiter

Overview:
Shares the single-port, synchronous-read instruction RAM between the core's instruction-fetch port and the debug AHB-Lite slave port (imem_dbg_ahb_*). The debug port is used for program load and readback.
Debug accesses normally win arbitration. A starvation counter guarantees forward progress for instruction fetch.
Sits inside the imem wrapper, between the fetch stage/debug bus and the RAM macro.

Parameters:
IMEM_AW, 10, RAM word-address width (1024 x 32-bit words = 4 KB)
STARVE_LIMIT, 4, maximum consecutive cycles the fetch port may be denied while requesting

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  fetch request
cpu_addr  in  IMEM_AW+2  fetch byte address; bits [1:0] ignored
cpu_gnt  out  1  fetch accepted this cycle (combinational)
cpu_rvalid  out  1  cpu_rdata valid; asserted one cycle after cpu_gnt
cpu_rdata  out  32  fetched word
imem_dbg_ahb_HSEL  in  1  slave select
imem_dbg_ahb_HADDR  in  16  byte address
imem_dbg_ahb_HTRANS  in  2  transfer type
imem_dbg_ahb_HWRITE  in  1  write when 1
imem_dbg_ahb_HSIZE  in  3  transfer size
imem_dbg_ahb_HREADY  in  1  bus-level ready
imem_dbg_ahb_HWDATA  in  32  write data (data phase)
imem_dbg_ahb_HRDATA  out  32  read data
imem_dbg_ahb_HREADYOUT  out  1  slave ready
imem_dbg_ahb_HRESP  out  1  0 = OKAY, 1 = ERROR
ram_en  out  1  RAM access strobe
ram_we  out  4  byte write enables; 0 = read
ram_addr  out  IMEM_AW  RAM word address
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data; valid the cycle after a read with ram_en=1

Behaviour:
- Reset (asynchronous): state IDLE, starve_cnt=0, captured address-phase registers cleared.
  Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, cpu_rvalid=0, cpu_gnt=0, ram_en=0, ram_we=0.
  Reset mid-transfer abandons the transfer; no RAM write is issued afterwards.
- Address phase capture: when HSEL & HREADY & HTRANS[1] & HREADYOUT, latch HADDR, HWRITE and HSIZE.
  IDLE or BUSY transfers, or HSEL=0, get OKAY with zero wait states and no RAM access.
- Decode of a captured transfer:
  - ERROR if HSIZE>2, if the address is misaligned (halfword with HADDR[0]=1, word with HADDR[1:0]!=0), or if HADDR[15:IMEM_AW+2]!=0.
  - Otherwise: byte enables = 0001<<HADDR[1:0] (byte), 0011<<{HADDR[1],1'b0} (halfword), 1111 (word).
- FSM states: IDLE, D_PEND, D_RDATA, ERR1, ERR2.
  - IDLE -> D_PEND on a valid transfer; IDLE -> ERR1 on an erroneous one.
  - D_PEND, debug wins the slot:
    - write: ram_en=1, ram_we=enables, ram_wdata=HWDATA, HREADYOUT=1 (zero wait states); next state IDLE, or D_PEND/ERR1 if a new transfer is captured.
    - read: ram_en=1, ram_we=0, HREADYOUT=0; next state D_RDATA.
  - D_PEND, debug loses the slot: HREADYOUT=0; stay in D_PEND.
  - D_RDATA: HRDATA=ram_rdata, HREADYOUT=1; a pipelined next transfer may be captured.
  - ERR1: HRESP=1, HREADYOUT=0. ERR2: HRESP=1, HREADYOUT=1. Then return to IDLE or capture the next transfer.
- Arbitration, once per cycle, between D_PEND and cpu_req:
  - Debug wins unless starve_cnt==STARVE_LIMIT; then the CPU wins and starve_cnt clears.
  - starve_cnt increments when cpu_req=1 and the CPU is denied. It clears when the CPU is granted or cpu_req=0. It saturates at STARVE_LIMIT.
  - If debug is not in D_PEND, the CPU is granted whenever it requests.
- CPU grant: ram_en=1, ram_we=0, ram_addr=cpu_addr[IMEM_AW+1:2], cpu_gnt=1. The following cycle cpu_rvalid=1 and cpu_rdata=ram_rdata.
  Back-to-back grants sustain one fetch per cycle.
- D_RDATA and ERR states do not use the RAM slot, so the CPU is free to be granted in those cycles.
- A read of an address written by the immediately preceding debug write returns the new data.
- Reads of HRDATA outside D_RDATA return the last value; no requirement is placed on it.

Test Plan:
- Debug word write: 0xDEADBEEF to HADDR 0x0010, then read it back with cpu_req=0. Required: write completes with zero wait states (ram_we=1111, ram_addr=4); read takes exactly one wait state; HRDATA=0xDEADBEEF; HRESP=0.
- Byte write of 0xAA to HADDR 0x0013 over word 0x11223344, then word read. Required: ram_we=1000; readback 0xAA223344.
- Errors: halfword access at HADDR 0x0001, word access at 0x1000, and HSIZE=3. Required for each: two-cycle ERROR (HREADYOUT 0 then 1, HRESP=1 on both cycles); ram_en never asserted.
- Contention: cpu_req held high while 8 back-to-back debug writes stream in. Required: the CPU is denied 4 cycles, granted on the 5th, and that debug write stalls exactly one cycle; all 8 writes land intact.
- Fetch-only: cpu_req high with addresses 0x0, 0x4, 0x8. Required: cpu_gnt every cycle; cpu_rvalid one cycle later carrying the matching words.
- Reset asserted during a D_PEND write. Required: outputs return to reset values immediately; the target word is unchanged afterwards.
